// File: rtl/sm_pkg.sv
// Shared encodings for the Simple RISC Machine control FSM:
// state enumeration, memory command, register select, writeback source and opcodes.
package sm_pkg;

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_IF1       = 5'd1,
        S_IF2       = 5'd2,
        S_UPDATE_PC = 5'd3,
        S_DECODE    = 5'd4,
        S_WRITE_IMM = 5'd5,
        S_GET_A     = 5'd6,
        S_GET_B     = 5'd7,
        S_EXEC      = 5'd8,
        S_WRITE_REG = 5'd9,
        S_ADDR_CALC = 5'd10,
        S_LOAD_ADDR = 5'd11,
        S_MEM_RD    = 5'd12,
        S_MEM_WB    = 5'd13,
        S_GET_RD    = 5'd14,
        S_PASS_B    = 5'd15,
        S_MEM_WR    = 5'd16,
        S_HALT      = 5'd17
    } state_t;

    // Memory command
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // Register-file port select handed to the decoder
    localparam logic [1:0] SEL_RM = 2'b00;
    localparam logic [1:0] SEL_RD = 2'b01;
    localparam logic [1:0] SEL_RN = 2'b10;

    // Writeback source
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Opcodes (ir[15:13])
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    // op field values (ir[12:11]) that steer the sequence
    localparam logic [1:0] OPF_ADD = 2'b00;
    localparam logic [1:0] OPF_CMP = 2'b01;
    localparam logic [1:0] OPF_IMM = 2'b10;
    localparam logic [1:0] OPF_MVN = 2'b11;

endpackage

// File: rtl/sm_controller.sv
// Moore control FSM for the Simple RISC Machine: fetch, decode, execute and
// writeback, one instruction at a time. Outputs depend only on the current
// state, except asel/load_s in EXEC which look at the (stable) decoded IR.
module sm_controller
    import sm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [1:0] reg_sel,
    output logic       write,
    output logic [1:0] vsel,
    output logic       load_a,
    output logic       load_b,
    output logic       load_c,
    output logic       load_s,
    output logic       asel,
    output logic       bsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd
);

    state_t state;
    state_t next_state;

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_RESET;
        else
            state <= next_state;
    end

    // Next-state decode and per-state strobes
    always_comb begin
        next_state = state;
        reg_sel    = SEL_RM;
        write      = 1'b0;
        vsel       = VSEL_C;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_c     = 1'b0;
        load_s     = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        load_ir    = 1'b0;
        load_pc    = 1'b0;
        reset_pc   = 1'b0;
        load_addr  = 1'b0;
        addr_sel   = 1'b0;
        mem_cmd    = MNONE;

        case (state)
            S_RESET: begin
                reset_pc   = 1'b1;
                load_pc    = 1'b1;
                next_state = S_IF1;
            end
            S_IF1: begin
                addr_sel   = 1'b1;
                mem_cmd    = MREAD;
                next_state = S_IF2;
            end
            S_IF2: begin
                addr_sel   = 1'b1;
                mem_cmd    = MREAD;
                load_ir    = 1'b1;
                next_state = S_UPDATE_PC;
            end
            S_UPDATE_PC: begin
                load_pc    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Unrecognised encodings fall back to IF1 and behave as a NOP
                case (opcode)
                    OP_MOV: begin
                        if (op == OPF_IMM)
                            next_state = S_WRITE_IMM;
                        else if (op == OPF_ADD)
                            next_state = S_GET_B;
                        else
                            next_state = S_IF1;
                    end
                    OP_ALU:  next_state = (op == OPF_MVN) ? S_GET_B : S_GET_A;
                    OP_LDR,
                    OP_STR:  next_state = (op == 2'b00) ? S_GET_A : S_IF1;
                    OP_HALT: next_state = S_HALT;
                    default: next_state = S_IF1;
                endcase
            end
            S_WRITE_IMM: begin
                reg_sel    = SEL_RN;
                vsel       = VSEL_IMM;
                write      = 1'b1;
                next_state = S_IF1;
            end
            S_GET_A: begin
                reg_sel    = SEL_RN;
                load_a     = 1'b1;
                next_state = (opcode == OP_LDR || opcode == OP_STR) ? S_ADDR_CALC : S_GET_B;
            end
            S_GET_B: begin
                reg_sel    = SEL_RM;
                load_b     = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                // Zeroing A turns the ALU into a pass/invert of shifted B
                load_c     = 1'b1;
                asel       = (opcode == OP_MOV) || (opcode == OP_ALU && op == OPF_MVN);
                load_s     = (opcode == OP_ALU && op == OPF_CMP);
                next_state = (opcode == OP_ALU && op == OPF_CMP) ? S_IF1 : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                reg_sel    = SEL_RD;
                vsel       = VSEL_C;
                write      = 1'b1;
                next_state = S_IF1;
            end
            S_ADDR_CALC: begin
                bsel       = 1'b1;
                load_c     = 1'b1;
                next_state = S_LOAD_ADDR;
            end
            S_LOAD_ADDR: begin
                load_addr  = 1'b1;
                next_state = (opcode == OP_LDR) ? S_MEM_RD : S_GET_RD;
            end
            S_MEM_RD: begin
                // Synchronous memory: data is valid one cycle after the read command
                mem_cmd    = MREAD;
                next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_cmd    = MREAD;
                reg_sel    = SEL_RD;
                vsel       = VSEL_MDATA;
                write      = 1'b1;
                next_state = S_IF1;
            end
            S_GET_RD: begin
                reg_sel    = SEL_RD;
                load_b     = 1'b1;
                next_state = S_PASS_B;
            end
            S_PASS_B: begin
                asel       = 1'b1;
                load_c     = 1'b1;
                next_state = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_cmd    = MWRITE;
                next_state = S_IF1;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_sm_controller.sv
// Directed testbench for sm_controller: walks each instruction class through
// its full state sequence and compares every output against hand-derived values.
module tb_sm_controller;

    logic       clk;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [1:0] reg_sel;
    logic       write;
    logic [1:0] vsel;
    logic       load_a, load_b, load_c, load_s;
    logic       asel, bsel;
    logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
    logic [1:0] mem_cmd;

    int n_checks = 0;
    int n_fails  = 0;

    sm_controller dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .op        (op),
        .reg_sel   (reg_sel),
        .write     (write),
        .vsel      (vsel),
        .load_a    (load_a),
        .load_b    (load_b),
        .load_c    (load_c),
        .load_s    (load_s),
        .asel      (asel),
        .bsel      (bsel),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .load_addr (load_addr),
        .addr_sel  (addr_sel),
        .mem_cmd   (mem_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {reg_sel, write, vsel, load_a, load_b, load_c, load_s,
    //                 asel, bsel, load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd}
    logic [17:0] outs;
    assign outs = {reg_sel, write, vsel, load_a, load_b, load_c, load_s,
                   asel, bsel, load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd};

    function automatic logic [17:0] ov(
        input logic [1:0] rs, input logic wr, input logic [1:0] vs,
        input logic la, input logic lb, input logic lc, input logic ls,
        input logic as, input logic bs, input logic lir, input logic lpc,
        input logic rpc, input logic lad, input logic ads, input logic [1:0] mc);
        return {rs, wr, vs, la, lb, lc, ls, as, bs, lir, lpc, rpc, lad, ads, mc};
    endfunction

    //                             rs     wr  vs    la lb lc ls as bs ir pc rp ad as mc
    localparam logic [17:0] O_RST   = ov(2'b00,0,2'b00,0,0,0,0,0,0,0,1,1,0,0,2'b00);
    localparam logic [17:0] O_IF1   = ov(2'b00,0,2'b00,0,0,0,0,0,0,0,0,0,0,1,2'b01);
    localparam logic [17:0] O_IF2   = ov(2'b00,0,2'b00,0,0,0,0,0,0,1,0,0,0,1,2'b01);
    localparam logic [17:0] O_UPD   = ov(2'b00,0,2'b00,0,0,0,0,0,0,0,1,0,0,0,2'b00);
    localparam logic [17:0] O_ZERO  = ov(2'b00,0,2'b00,0,0,0,0,0,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_WIMM  = ov(2'b10,1,2'b10,0,0,0,0,0,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_GETA  = ov(2'b10,0,2'b00,1,0,0,0,0,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_GETB  = ov(2'b00,0,2'b00,0,1,0,0,0,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_EXADD = ov(2'b00,0,2'b00,0,0,1,0,0,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_EXCMP = ov(2'b00,0,2'b00,0,0,1,1,0,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_EXMOV = ov(2'b00,0,2'b00,0,0,1,0,1,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_WREG  = ov(2'b01,1,2'b00,0,0,0,0,0,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_ADDR  = ov(2'b00,0,2'b00,0,0,1,0,0,1,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_LADDR = ov(2'b00,0,2'b00,0,0,0,0,0,0,0,0,0,1,0,2'b00);
    localparam logic [17:0] O_MRD   = ov(2'b00,0,2'b00,0,0,0,0,0,0,0,0,0,0,0,2'b01);
    localparam logic [17:0] O_MWB   = ov(2'b01,1,2'b11,0,0,0,0,0,0,0,0,0,0,0,2'b01);
    localparam logic [17:0] O_GETRD = ov(2'b01,0,2'b00,0,1,0,0,0,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_PASSB = ov(2'b00,0,2'b00,0,0,1,0,1,0,0,0,0,0,0,2'b00);
    localparam logic [17:0] O_MWR   = ov(2'b00,0,2'b00,0,0,0,0,0,0,0,0,0,0,0,2'b10);

    task automatic chk(input string tag, input logic [17:0] expected);
        n_checks++;
        assert (outs === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %05h expected %05h", tag, outs, expected);
        end
    endtask

    // Advance one clock, then compare the new state's outputs
    task automatic step(input string tag, input logic [17:0] expected);
        @(posedge clk);
        #1;
        chk(tag, expected);
    endtask

    // Common front end: called while in IF1 with the instruction presented
    task automatic fetch(input string name, input logic [2:0] oc, input logic [1:0] o);
        opcode = oc;
        op     = o;
        step({name, "_if2"}, O_IF2);
        step({name, "_upd"}, O_UPD);
        step({name, "_dec"}, O_ZERO);
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 3'b000;
        op     = 2'b00;
        #1;
        chk("reset_t0", O_RST);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_held", O_RST);
        #2 reset = 1'b0;
        step("post_reset_if1", O_IF1);

        // MOV immediate: 5 states IF1..WRITE_IMM
        fetch("movi", 3'b110, 2'b10);
        step("movi_wimm", O_WIMM);
        step("movi_if1", O_IF1);

        // ADD
        fetch("add", 3'b101, 2'b00);
        step("add_geta", O_GETA);
        step("add_getb", O_GETB);
        step("add_exec", O_EXADD);
        step("add_wreg", O_WREG);
        step("add_if1", O_IF1);

        // CMP: status only, no writeback
        fetch("cmp", 3'b101, 2'b01);
        step("cmp_geta", O_GETA);
        step("cmp_getb", O_GETB);
        step("cmp_exec", O_EXCMP);
        step("cmp_if1", O_IF1);

        // MOV register (shifted)
        fetch("movr", 3'b110, 2'b00);
        step("movr_getb", O_GETB);
        step("movr_exec", O_EXMOV);
        step("movr_wreg", O_WREG);
        step("movr_if1", O_IF1);

        // MVN
        fetch("mvn", 3'b101, 2'b11);
        step("mvn_getb", O_GETB);
        step("mvn_exec", O_EXMOV);
        step("mvn_wreg", O_WREG);
        step("mvn_if1", O_IF1);

        // LDR
        fetch("ldr", 3'b011, 2'b00);
        step("ldr_geta", O_GETA);
        step("ldr_addr", O_ADDR);
        step("ldr_laddr", O_LADDR);
        step("ldr_memrd", O_MRD);
        step("ldr_memwb", O_MWB);
        step("ldr_if1", O_IF1);

        // STR
        fetch("str", 3'b100, 2'b00);
        step("str_geta", O_GETA);
        step("str_addr", O_ADDR);
        step("str_laddr", O_LADDR);
        step("str_getrd", O_GETRD);
        step("str_passb", O_PASSB);
        step("str_memwr", O_MWR);
        step("str_if1", O_IF1);

        // Illegal encodings act as NOPs
        fetch("ill001", 3'b001, 2'b00);
        step("ill001_if1", O_IF1);
        fetch("ill110_01", 3'b110, 2'b01);
        step("ill110_01_if1", O_IF1);

        // Asynchronous reset in the middle of EXEC
        fetch("rst_add", 3'b101, 2'b00);
        step("rst_add_geta", O_GETA);
        step("rst_add_getb", O_GETB);
        step("rst_add_exec", O_EXADD);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_same_cycle", O_RST);
        @(posedge clk); #1;
        chk("async_reset_held", O_RST);
        #2 reset = 1'b0;
        step("rst_release_if1", O_IF1);

        // HALT: stays put with all outputs low while opcode wanders
        fetch("halt", 3'b111, 2'b00);
        step("halt_enter", O_ZERO);
        for (int i = 0; i < 22; i++) begin
            opcode = 3'(i + 1);
            op     = 2'(i);
            step("halt_hold", O_ZERO);
        end

        // Only reset leaves HALT
        #2 reset = 1'b1;
        #1;
        chk("halt_reset", O_RST);
        #3 reset = 1'b0;
        step("halt_exit_if1", O_IF1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
